// File: rtl/led_pwm_sequencer.sv
// 16-channel PWM LED sequencer with shadowed duty registers committed at the period boundary.
// Optional breathing fade engine compiled in with `define LED_PWM_FADE_EN.
module led_pwm_sequencer #(
   parameter int unsigned PERIOD       = 100_000,
   parameter int unsigned CNT_W        = 17,
   parameter int unsigned FADE_STEP    = 1_000,
   parameter int unsigned FADE_PERIODS = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [3:0]       cfg_chan,
   input  logic [CNT_W-1:0] cfg_duty,
   input  logic [15:0]      sw,
   input  logic [15:0]      fade_mask,
   output logic [15:0]      led,
   output logic             period_start
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] PER  = CNT_W'(PERIOD);

   logic             run_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ps_q, ps_d;
   logic [15:0]      led_q, led_d;
   logic [CNT_W-1:0] shadow_q [16];
   logic [CNT_W-1:0] shadow_d [16];
   logic [CNT_W-1:0] active_q [16];
   logic [CNT_W-1:0] active_d [16];
   logic [CNT_W-1:0] eff;
   logic             commit;
   logic             accept;
   logic [15:0]      use_fade;
   logic [CNT_W-1:0] fade_duty;

   // run_q holds cnt at 0 on the first edge after release, so that cycle opens a period
   assign commit       = run_q && (cnt_q == LAST);
   assign cfg_ready    = run_q && !commit;
   assign accept       = cfg_valid && cfg_ready;
   assign led          = led_q;
   assign period_start = ps_q;

   always_comb begin
      if (!run_q || (cnt_q == LAST)) cnt_d = '0;
      else                           cnt_d = cnt_q + 1'b1;
      ps_d = (cnt_d == '0);

      shadow_d = shadow_q;
      if (accept) shadow_d[cfg_chan] = cfg_duty;

      if (commit) active_d = shadow_q;
      else        active_d = active_q;

      eff   = '0;
      led_d = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (use_fade[i])            eff = fade_duty;
         else if (active_q[i] > PER) eff = PER;
         else                        eff = active_q[i];
         led_d[i] = sw[i] && (cnt_q < eff);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         ps_q  <= 1'b0;
         led_q <= '0;
         for (int unsigned i = 0; i < 16; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         run_q    <= 1'b1;
         cnt_q    <= cnt_d;
         ps_q     <= ps_d;
         led_q    <= led_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

`ifdef LED_PWM_FADE_EN
   localparam int unsigned      FW        = $clog2(FADE_PERIODS + 1);
   localparam logic [FW-1:0]    FCNT_LAST = FW'(FADE_PERIODS - 1);
   localparam logic [CNT_W:0]   STEP_W    = (CNT_W + 1)'(FADE_STEP);

   typedef enum logic {FADE_UP, FADE_DOWN} fade_state_e;

   fade_state_e      state_q, state_d;
   logic [CNT_W-1:0] fduty_q, fduty_d;
   logic [FW-1:0]    fcnt_q, fcnt_d;
   logic [15:0]      fmask_q, fmask_d;
   logic [CNT_W:0]   up_sum;

   assign use_fade  = fmask_q;
   assign fade_duty = fduty_q;

   always_comb begin
      state_d = state_q;
      fduty_d = fduty_q;
      fcnt_d  = fcnt_q;
      fmask_d = fmask_q;
      // one extra bit keeps the upward sum from wrapping before the clamp
      up_sum  = {1'b0, fduty_q} + STEP_W;
      if (commit) begin
         fmask_d = fade_mask;
         if (fcnt_q == FCNT_LAST) begin
            fcnt_d = '0;
            unique case (state_q)
               FADE_UP: begin
                  if (up_sum >= {1'b0, PER}) begin
                     fduty_d = PER;
                     state_d = FADE_DOWN;
                  end else begin
                     fduty_d = up_sum[CNT_W-1:0];
                  end
               end
               FADE_DOWN: begin
                  if ({1'b0, fduty_q} <= STEP_W) begin
                     fduty_d = '0;
                     state_d = FADE_UP;
                  end else begin
                     fduty_d = fduty_q - STEP_W[CNT_W-1:0];
                  end
               end
            endcase
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FADE_UP;
         fduty_q <= '0;
         fcnt_q  <= '0;
         fmask_q <= '0;
      end else begin
         state_q <= state_d;
         fduty_q <= fduty_d;
         fcnt_q  <= fcnt_d;
         fmask_q <= fmask_d;
      end
   end
`else
   logic [15:0] unused_fade_mask;

   assign unused_fade_mask = fade_mask;
   assign use_fade         = '0;
   assign fade_duty        = '0;
`endif

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Scoreboard bench for led_pwm_sequencer: a period/write-log reference model queues the
// expected led/period_start/cfg_ready per cycle and a negedge monitor compares them.
module tb_led_pwm_sequencer;

   localparam int unsigned PERIOD       = 10;
   localparam int unsigned CNT_W        = 4;
   localparam int unsigned FADE_STEP    = 5;
   localparam int unsigned FADE_PERIODS = 1;
`ifdef LED_PWM_FADE_EN
   localparam bit FADE_BUILD = 1'b1;
`else
   localparam bit FADE_BUILD = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [3:0]       cfg_chan = '0;
   logic [CNT_W-1:0] cfg_duty = '0;
   logic [15:0]      sw = 16'hFFFF;
   logic [15:0]      fade_mask = '0;
   logic [15:0]      led;
   logic             period_start;

   led_pwm_sequencer #(
      .PERIOD      (PERIOD),
      .CNT_W       (CNT_W),
      .FADE_STEP   (FADE_STEP),
      .FADE_PERIODS(FADE_PERIODS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_chan    (cfg_chan),
      .cfg_duty    (cfg_duty),
      .sw          (sw),
      .fade_mask   (fade_mask),
      .led         (led),
      .period_start(period_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned chan;
      int unsigned per;
      int unsigned duty;
   } wr_t;

   typedef struct packed {
      logic [15:0] led;
      logic        ps;
      logic        rdy;
   } exp_t;

   wr_t         wlog[$];
   exp_t        expq[$];
   int unsigned k = 0;
   int unsigned m_cnt = 0;
   logic [15:0] cur_mask = '0;
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   // duty seen by channel c during period per: last write accepted in any earlier period
   function automatic int unsigned duty_of(input int unsigned c, input int unsigned per);
      int unsigned d = 0;
      foreach (wlog[i]) if (wlog[i].chan == c && wlog[i].per < per) d = wlog[i].duty;
      return d;
   endfunction

   // breathing value after per commits, stepping every FADE_PERIODS commits
   function automatic int unsigned fade_at(input int unsigned per);
      int unsigned v  = 0;
      bit          up = 1'b1;
      for (int unsigned s = 0; s < per / FADE_PERIODS; s++) begin
         if (up) begin
            v += FADE_STEP;
            if (v >= PERIOD) begin v = PERIOD; up = 1'b0; end
         end else if (v <= FADE_STEP) begin
            v = 0; up = 1'b1;
         end else begin
            v -= FADE_STEP;
         end
      end
      return v;
   endfunction

   // reference model: k counts edges since the last reset edge; cnt during a cycle is (k-1)%PERIOD
   always @(posedge clk) begin
      exp_t        e;
      int unsigned cprev, pprev, eff;
      e = '0;
      if (!rst_n) begin
         k = 0;
         m_cnt = 0;
         wlog.delete();
         cur_mask = '0;
      end else begin
         k++;
         m_cnt = (k - 1) % PERIOD;
         if (k >= 2) begin
            cprev = (k - 2) % PERIOD;
            pprev = (k - 2) / PERIOD;
            for (int c = 0; c < 16; c++) begin
               eff = duty_of(c, pprev);
               if (eff > PERIOD) eff = PERIOD;
               if (FADE_BUILD && cur_mask[c]) eff = fade_at(pprev);
               e.led[c] = sw[c] && (cprev < eff);
            end
            if (cfg_valid && cprev != PERIOD - 1)
               wlog.push_back('{int'(cfg_chan), pprev, int'(cfg_duty)});
            if (cprev == PERIOD - 1) cur_mask = fade_mask;
         end
         e.ps  = (m_cnt == 0);
         e.rdy = (m_cnt != PERIOD - 1);
      end
      expq.push_back(e);
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         chk("led", led, e.led);
         chk("period_start", 16'(period_start), 16'(e.ps));
         chk("cfg_ready", 16'(cfg_ready), 16'(e.rdy));
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_cnt(input int unsigned v);
      for (int i = 0; i < 2 * PERIOD && m_cnt != v; i++) tick(1);
   endtask

   task automatic wr(input int unsigned ch, input int unsigned d);
      if (m_cnt == PERIOD - 1) tick(1);
      cfg_valid = 1'b1;
      cfg_chan  = 4'(ch);
      cfg_duty  = CNT_W'(d);
      tick(1);
      cfg_valid = 1'b0;
   endtask

   initial begin
      tick(3);
      rst_n = 1'b1;
      tick(1);

      sw = 16'h0001;
      wait_cnt(2);
      wr(0, 3);
      tick(3 * PERIOD);

      sw = 16'h000F;
      wait_cnt(1);
      wr(1, 0);
      wr(2, 10);
      wr(3, 15);
      tick(2 * PERIOD);

      wait_cnt(PERIOD - 1);
      cfg_valid = 1'b1;
      cfg_chan  = 4'd5;
      cfg_duty  = 4'd6;
      tick(2);
      cfg_valid = 1'b0;
      sw = 16'hFFFF;
      wait_cnt(1);
      wr(4, 2);
      wr(4, 7);
      tick(2 * PERIOD);

      for (int unsigned c = 0; c < 16; c++) wr(c, 5);
      tick(2 * PERIOD);
      wait_cnt(2);
      sw = 16'h00FF;
      tick(2 * PERIOD);

      sw = 16'hFFFF;
      fade_mask = 16'h0001;
      tick(6 * PERIOD);

      for (int i = 0; i < 300; i++) begin
         cfg_valid = 1'($urandom_range(0, 1));
         cfg_chan  = 4'($urandom_range(0, 15));
         cfg_duty  = CNT_W'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
         if ($urandom_range(0, 15) == 0) fade_mask = 16'($urandom);
         tick(1);
      end
      cfg_valid = 1'b0;

      wait_cnt(3);
      wr(6, 9);
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      sw = 16'hFFFF;
      tick(3 * PERIOD);

      for (int i = 0; i < 200; i++) begin
         cfg_valid = 1'($urandom_range(0, 1));
         cfg_chan  = 4'($urandom_range(0, 15));
         cfg_duty  = CNT_W'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
         if ($urandom_range(0, 15) == 0) fade_mask = 16'($urandom);
         tick(1);
      end
      cfg_valid = 1'b0;
      tick(2);
      @(negedge clk);
      #1;
      if (n_checks < 12) begin
         n_fail++;
         $display("FAIL check_count: got %0d comparisons, expected at least 12", n_checks);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
